inverter_selftest_checker: RTL and testbench
============================================

// Module: inverter_selftest_checker
// PURPOSE
//   Receiving end of the inverter stimulus path. The stimulus (a toggling clock-like
//   signal driving the inverter under test) and the inverter's response enter here.
//   Over a programmed window the block checks response == ~stimulus every cycle,
//   counts mismatches and stimulus rising edges, then reports pass/fail.
//   Sits on the board as the on-chip self-test for the inverter path.
//   Results drive the board LEDs.
// PARAMETERS
//   SETTLE_CYCLES  4   clocks ignored after start, before checking begins (>=1)
//   CHECK_CYCLES   16  clocks compared in the check window (>=1)
//   MIN_EDGES      1   minimum stimulus rising edges required for pass
//   COUNT_WIDTH    8   width of errorCount/edgeCount; both saturate at all-ones
// PORTS
//   clock       in   1            system clock, all logic on rising edge
//   resetN      in   1            asynchronous, active-low reset
//   start       in   1            pulse/level; sampled only in IDLE and DONE
//   abort       in   1            returns to IDLE from any state
//   stimulus    in   1            stimulus as driven into the DUT (async to clock)
//   response    in   1            DUT output (async to clock)
//   busy        out  1            1 in SETTLE or CHECK
//   done        out  1            1 in DONE
//   pass        out  1            valid while done=1, else 0
//   errorCount  out  COUNT_WIDTH  mismatches counted in the window
//   edgeCount   out  COUNT_WIDTH  stimulus rising edges counted in the window
// BEHAVIOUR
//   - Reset (resetN=0, immediate): state=IDLE, synchronizers=0, prevA=0,
//     counters=0, busy=done=pass=0, errorCount=edgeCount=0.
//     Reset mid-operation discards the run.
//   - Synchronizer: stimulus and response each pass through 2 flops (syncA, syncB).
//     Checking uses only the synchronized copies, so results trail the pins by 2 clocks.
//   - FSM states: IDLE, SETTLE, CHECK, DONE.
//     IDLE:   start=1 -> SETTLE; clear errorCount, edgeCount, cycle counter.
//     SETTLE: count SETTLE_CYCLES clocks, then -> CHECK; on that transition prevA<=syncA
//             (no edge counted on CHECK entry).
//     CHECK:  every clock, if syncB == syncA then errorCount++.
//             if syncA=1 && prevA=0 then edgeCount++.
//             prevA<=syncA. After exactly CHECK_CYCLES clocks -> DONE.
//     DONE:   done=1; pass=(errorCount==0)&&(edgeCount>=MIN_EDGES); counts held;
//             start=1 -> SETTLE (counters cleared, done/pass drop next clock).
//   - start is ignored in SETTLE/CHECK. abort=1 in any state -> IDLE next clock,
//     counters keep their last values, done=pass=0. abort beats start.
//   - Counters saturate at 2^COUNT_WIDTH-1 and never wrap.
//   - busy/done/pass are registered outputs decoded from state; pass is 0 outside DONE.
//   - start to done latency: SETTLE_CYCLES+CHECK_CYCLES+1 clocks.
// TESTING (SETTLE=4, CHECK=16, MIN_EDGES=1, COUNT_WIDTH=8 unless noted)
//   1 stimulus toggles every clock, response=~stimulus, pulse start
//     -> done after 21 clocks, errorCount=0, edgeCount=8, pass=1
//   2 stimulus toggling, response stuck 0
//     -> errorCount=8, edgeCount=8, pass=0
//   3 stimulus toggling, response=stimulus (buffer)
//     -> errorCount=16, pass=0. Repeat with COUNT_WIDTH=3 -> errorCount=7 (saturated)
//   4 stimulus held 0, response=1
//     -> errorCount=0, edgeCount=0, pass=0 (MIN_EDGES not met)
//   5 start pulses during CHECK ignored (done at 21 clocks).
//     resetN low in mid-CHECK -> all outputs 0 immediately, state IDLE
//   6 abort during CHECK -> IDLE next clock, busy=0, done=0.
//     Restart from DONE with start -> counters cleared, new run passes as in 1

Source files
------------

// File: rtl/inverter_selftest_checker_if.sv
// Bundle between the inverter self-test checker and its surroundings: run control,
// the stimulus/response pair from the inverter path, and the status/result outputs.
interface inverter_selftest_checker_if #(
   parameter int COUNT_WIDTH = 8
);
   logic                   start;
   logic                   abort;
   logic                   stimulus;
   logic                   response;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic [COUNT_WIDTH-1:0] errorCount;
   logic [COUNT_WIDTH-1:0] edgeCount;

   modport master (
      output start, abort, stimulus, response,
      input  busy, done, pass, errorCount, edgeCount
   );

   modport slave (
      input  start, abort, stimulus, response,
      output busy, done, pass, errorCount, edgeCount
   );
endinterface

// File: rtl/inverter_selftest_checker.sv
// Inverter path self-test: synchronizes stimulus and response, lets the path settle,
// then over a fixed window checks response == ~stimulus each clock, counts mismatches
// and stimulus rising edges, and reports pass/fail for the board LEDs.
module inverter_selftest_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CHECK_CYCLES  = 16,
   parameter int MIN_EDGES     = 1,
   parameter int COUNT_WIDTH   = 8
) (
   input logic                      clock,
   input logic                      resetN,
   inverter_selftest_checker_if.slave bus
);

   localparam int MAX_CYC = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
   localparam int CYC_W   = $clog2(MAX_CYC + 1);
   localparam logic [CYC_W-1:0]       SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
   localparam logic [CYC_W-1:0]       CHECK_LAST  = CYC_W'(CHECK_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t                 state;
   logic [CYC_W-1:0]       cyc_cnt;
   logic                   stim_p0, stim_p1;   // stim_p1 is the synchronized stimulus (syncA)
   logic                   resp_p0, resp_p1;   // resp_p1 is the synchronized response (syncB)
   logic                   prev_a;
   logic [COUNT_WIDTH-1:0] err_cnt;
   logic [COUNT_WIDTH-1:0] edg_cnt;
   logic                   busy_r, done_r, pass_r;

   logic                   mismatch;
   logic                   rise;
   logic [COUNT_WIDTH-1:0] err_upd;
   logic [COUNT_WIDTH-1:0] edg_upd;
   logic                   pass_upd;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // A healthy inverter never shows equal synchronized levels.
   assign mismatch = (resp_p1 == stim_p1);
   assign rise     = stim_p1 & ~prev_a;
   assign err_upd  = mismatch ? sat_inc(err_cnt) : err_cnt;
   assign edg_upd  = rise ? sat_inc(edg_cnt) : edg_cnt;
   // Verdict is taken from the counts as they stand after the final window clock.
   assign pass_upd = (err_upd == '0) && (32'(edg_upd) >= $unsigned(MIN_EDGES));

   // Two-flop synchronizers for the asynchronous stimulus and response pins.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         stim_p0 <= 1'b0;
         stim_p1 <= 1'b0;
         resp_p0 <= 1'b0;
         resp_p1 <= 1'b0;
      end else begin
         stim_p0 <= bus.stimulus;
         stim_p1 <= stim_p0;
         resp_p0 <= bus.response;
         resp_p1 <= resp_p0;
      end
   end

   // Run sequencer: settle, check window, hold result; abort always wins.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         prev_a  <= 1'b0;
         err_cnt <= '0;
         edg_cnt <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else if (bus.abort) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state   <= SETTLE;
                  cyc_cnt <= '0;
                  err_cnt <= '0;
                  edg_cnt <= '0;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  pass_r  <= 1'b0;
               end
            end
            SETTLE: begin
               if (cyc_cnt == SETTLE_LAST) begin
                  state   <= CHECK;
                  cyc_cnt <= '0;
                  // Seed the edge detector so entering CHECK never counts an edge.
                  prev_a  <= stim_p1;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            CHECK: begin
               err_cnt <= err_upd;
               edg_cnt <= edg_upd;
               prev_a  <= stim_p1;
               if (cyc_cnt == CHECK_LAST) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  pass_r <= pass_upd;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               pass_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.pass       = pass_r;
   assign bus.errorCount = err_cnt;
   assign bus.edgeCount  = edg_cnt;

endmodule

// File: tb/tb_inverter_selftest_checker.sv
// Bench for the inverter self-test checker: two instances (8-bit and 3-bit counters)
// see identical inputs and are compared every clock against a run-level model.
module tb_inverter_selftest_checker;

   localparam int S  = 4;
   localparam int C  = 16;
   localparam int ME = 1;

   logic clock = 1'b0;
   logic resetN;
   int   nvec = 0;
   int   nbad = 0;

   // Model: mode 0 = idle, 1 = running, 2 = finished; age = clocks since accepted start.
   int   m_mode, m_age, m_err, m_edg;
   logic m_prev;
   logic d1s, d2s, d1r, d2r;   // pin history: last two sampled stimulus/response values
   logic tog = 1'b0;

   always #5 clock = ~clock;

   inverter_selftest_checker_if #(.COUNT_WIDTH(8)) bus8 ();
   inverter_selftest_checker_if #(.COUNT_WIDTH(3)) bus3 ();

   inverter_selftest_checker #(.SETTLE_CYCLES(S), .CHECK_CYCLES(C), .MIN_EDGES(ME), .COUNT_WIDTH(8))
      dut8 (.clock(clock), .resetN(resetN), .bus(bus8.slave));
   inverter_selftest_checker #(.SETTLE_CYCLES(S), .CHECK_CYCLES(C), .MIN_EDGES(ME), .COUNT_WIDTH(3))
      dut3 (.clock(clock), .resetN(resetN), .bus(bus3.slave));

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // 0 inverter, 1 stuck 0, 2 buffer, 3 stuck 1, other: inverter with occasional glitches
   function automatic logic rsel(input logic s, input int m);
      case (m)
         0:       return ~s;
         1:       return 1'b0;
         2:       return s;
         3:       return 1'b1;
         default: return ($urandom % 8 == 0) ? s : ~s;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_err = 0; m_edg = 0; m_prev = 1'b0;
      d1s = 1'b0; d2s = 1'b0; d1r = 1'b0; d2r = 1'b0;
   endtask

   // Advance the model by one clock using the inputs present at that edge.
   task automatic model_step(input logic st, input logic ab, input logic s, input logic r);
      logic sa, sb;
      sa = d2s;
      sb = d2r;
      if (ab) begin
         m_mode = 0;
      end else if (m_mode != 1) begin
         if (st) begin
            m_mode = 1; m_age = 0; m_err = 0; m_edg = 0;
         end
      end else begin
         m_age++;
         if (m_age == S) begin
            m_prev = sa;
         end else if (m_age > S) begin
            if (sb == sa) m_err++;
            if (sa && !m_prev) m_edg++;
            m_prev = sa;
            if (m_age == S + C) m_mode = 2;
         end
      end
      d2s = d1s; d1s = s;
      d2r = d1r; d1r = r;
   endtask

   task automatic compare_all();
      int ep;
      ep = (m_mode == 2 && m_err == 0 && m_edg >= ME) ? 1 : 0;
      chk("busy8", int'(bus8.busy), (m_mode == 1) ? 1 : 0);
      chk("done8", int'(bus8.done), (m_mode == 2) ? 1 : 0);
      chk("pass8", int'(bus8.pass), ep);
      chk("err8",  int'(bus8.errorCount), sat(m_err, 8));
      chk("edge8", int'(bus8.edgeCount),  sat(m_edg, 8));
      chk("busy3", int'(bus3.busy), (m_mode == 1) ? 1 : 0);
      chk("done3", int'(bus3.done), (m_mode == 2) ? 1 : 0);
      chk("err3",  int'(bus3.errorCount), sat(m_err, 3));
      chk("edge3", int'(bus3.edgeCount),  sat(m_edg, 3));
   endtask

   task automatic drive(input logic st, input logic ab, input logic s, input logic r);
      bus8.start = st; bus8.abort = ab; bus8.stimulus = s; bus8.response = r;
      bus3.start = st; bus3.abort = ab; bus3.stimulus = s; bus3.response = r;
   endtask

   // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
   task automatic cyc(input logic st, input logic ab, input logic s, input logic r);
      drive(st, ab, s, r);
      @(posedge clock);
      model_step(st, ab, s, r);
      @(negedge clock);
      compare_all();
   endtask

   // Start a run and clock until done (bounded); lat counts clocks including the start clock.
   task automatic run(input int rmode, input bit toggle, input bit noisy, output int lat);
      logic s;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         if (toggle) tog = ~tog;
         s = toggle ? tog : 1'b0;
         cyc((i == 0) ? 1'b1 : (noisy ? ($urandom % 2 == 1) : 1'b0), 1'b0, s, rsel(s, rmode));
         lat++;
         if (bus8.done === 1'b1) break;
      end
      chk("run_reaches_done", int'(bus8.done === 1'b1), 1);
   endtask

   initial begin
      int lat;
      logic s;
      int rm;
      bit tg;

      resetN = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clock);
      chk("reset_busy", int'(bus8.busy), 0);
      chk("reset_done", int'(bus8.done), 0);
      chk("reset_pass", int'(bus8.pass), 0);
      chk("reset_err",  int'(bus8.errorCount), 0);
      chk("reset_edge", int'(bus8.edgeCount), 0);
      resetN = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Healthy inverter
      run(0, 1'b1, 1'b0, lat);
      chk("t1_latency", lat, 21);
      chk("t1_err",  int'(bus8.errorCount), 0);
      chk("t1_edge", int'(bus8.edgeCount), 8);
      chk("t1_pass", int'(bus8.pass), 1);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Response stuck low
      run(1, 1'b1, 1'b0, lat);
      chk("t2_err",  int'(bus8.errorCount), 8);
      chk("t2_edge", int'(bus8.edgeCount), 8);
      chk("t2_pass", int'(bus8.pass), 0);

      // Buffer instead of inverter, plus narrow-counter saturation
      run(2, 1'b1, 1'b0, lat);
      chk("t3_err",  int'(bus8.errorCount), 16);
      chk("t3_err_w3", int'(bus3.errorCount), 7);
      chk("t3_pass", int'(bus8.pass), 0);

      // No stimulus activity
      run(3, 1'b0, 1'b0, lat);
      chk("t4_err",  int'(bus8.errorCount), 0);
      chk("t4_edge", int'(bus8.edgeCount), 0);
      chk("t4_pass", int'(bus8.pass), 0);

      // Restart straight from DONE: counters clear on the start clock
      tog = ~tog;
      cyc(1'b1, 1'b0, tog, ~tog);
      chk("restart_err_clr", int'(bus8.errorCount), 0);
      chk("restart_done_drop", int'(bus8.done), 0);
      for (int i = 0; i < 40 && bus8.done !== 1'b1; i++) begin
         tog = ~tog;
         cyc(1'b0, 1'b0, tog, ~tog);
      end
      chk("restart_pass", int'(bus8.pass), 1);
      chk("restart_edge", int'(bus8.edgeCount), 8);

      // Start pulses during the run are ignored
      run(0, 1'b1, 1'b1, lat);
      chk("t5_latency", lat, 21);
      chk("t5_pass", int'(bus8.pass), 1);

      // Reset in the middle of CHECK
      tog = ~tog;
      cyc(1'b1, 1'b0, tog, ~tog);
      for (int i = 0; i < 10; i++) begin
         tog = ~tog;
         cyc(1'b0, 1'b0, tog, ~tog);
      end
      #2 resetN = 1'b0;
      #1;
      chk("midrst_busy", int'(bus8.busy), 0);
      chk("midrst_done", int'(bus8.done), 0);
      chk("midrst_pass", int'(bus8.pass), 0);
      chk("midrst_edge", int'(bus8.edgeCount), 0);
      chk("midrst_err3", int'(bus3.errorCount), 0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      resetN = 1'b1;
      compare_all();

      // Abort during CHECK, counts retained
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tog = ~tog;
         cyc(1'b0, 1'b0, tog, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort_busy", int'(bus8.busy), 0);
      chk("abort_done", int'(bus8.done), 0);
      chk("abort_err_kept", int'(bus8.errorCount), 3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_idle", int'(bus8.busy), 0);

      // Randomized traffic: random starts/aborts, mixed response faults
      rm = 0;
      tg = 1'b1;
      for (int i = 0; i < 900; i++) begin
         if (i % 45 == 0) begin
            rm = $urandom_range(5, 0);
            tg = ($urandom % 4 != 0);
         end
         if (tg) tog = ~tog;
         else    tog = ($urandom % 2 == 1);
         s = tog;
         cyc(($urandom % 6 == 0), ($urandom % 50 == 0), s, rsel(s, rm));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
